// File: rtl/alu_issuer_if.sv
// Signal bundle between the ALU issuer, its command/response neighbours and the ALU.
// The master modport is the issuer's view; slave is everything around it.
interface alu_issuer_if #(
    parameter int N = 4
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [4:0]   cmd_opcode;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic         alu_start;
    logic         alu_finished;
    logic [4:0]   alu_opcode;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [N-1:0] alu_y;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_y;
    logic         rsp_timeout;
    logic         busy;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_finished, alu_y, rsp_ready,
        output cmd_ready, alu_start, alu_opcode, alu_a, alu_b, rsp_valid, rsp_y,
               rsp_timeout, busy
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_finished, alu_y, rsp_ready,
        input  cmd_ready, alu_start, alu_opcode, alu_a, alu_b, rsp_valid, rsp_y,
               rsp_timeout, busy
    );
endinterface

// File: rtl/alu_issuer.sv
// Launches one command at a time on the ALU start/finished handshake and returns the
// result (or a timeout marker) on a valid/ready response channel.
module alu_issuer #(
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic         clock,
    input  logic         reset,
    alu_issuer_if.master bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESPOND
    } state_t;

    state_t       r_state;
    state_t       w_nextState;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_countNext;
    logic [4:0]   r_opcode;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [N-1:0] r_rspY;
    logic         r_rspTimeout;
    logic         w_cmdReady;
    logic         w_accept;
    logic         w_timeUp;

    // A held-high finished from the ALU keeps new commands out until it drops.
    assign w_cmdReady  = (r_state == IDLE) && !bus.alu_finished && !reset;
    assign w_accept    = bus.cmd_valid && w_cmdReady;
    assign w_countNext = r_count + 1'b1;
    assign w_timeUp    = (w_countNext == CW'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        bus.alu_start = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.busy      = 1'b1;
        case (r_state)
            IDLE: begin
                bus.busy = 1'b0;
                if (w_accept) begin
                    w_nextState = LAUNCH;
                end
            end
            LAUNCH: begin
                bus.alu_start = 1'b1;
                w_nextState   = WAIT;
            end
            WAIT: begin
                if (bus.alu_finished || w_timeUp) begin
                    w_nextState = RESPOND;
                end
            end
            RESPOND: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Finished takes priority over the timeout when both land on the same WAIT cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count      <= '0;
            r_opcode     <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_rspY       <= '0;
            r_rspTimeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_opcode <= bus.cmd_opcode;
                        r_a      <= bus.cmd_a;
                        r_b      <= bus.cmd_b;
                    end
                end
                LAUNCH: begin
                    r_count <= '0;
                end
                WAIT: begin
                    r_count <= w_countNext;
                    if (bus.alu_finished) begin
                        r_rspY       <= bus.alu_y;
                        r_rspTimeout <= 1'b0;
                    end else if (w_timeUp) begin
                        r_rspY       <= '0;
                        r_rspTimeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cmd_ready   = w_cmdReady;
    assign bus.alu_opcode  = r_opcode;
    assign bus.alu_a       = r_a;
    assign bus.alu_b       = r_b;
    assign bus.rsp_y       = r_rspY;
    assign bus.rsp_timeout = r_rspTimeout;
endmodule

// File: tb/tb_alu_issuer.sv
// Randomised and directed bench for alu_issuer: an ALU stand-in, a transaction-level
// model of when starts and responses must appear, and a per-cycle compare process.
module tb_alu_issuer;
    localparam int N       = 4;
    localparam int TIMEOUT = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    alu_issuer_if #(.N(N)) bus ();

    alu_issuer #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    always @(posedge clock) cyc = cyc + 1;

    function automatic logic [N-1:0] aluRef(input logic [4:0] op, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        case (op[1:0])
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // ALU stand-in: finished pulses a per-command number of cycles after start (0 = never).
    int           latQ[$];
    int           aluCd     = 0;
    logic [N-1:0] aluHeldY  = '0;
    logic [N-1:0] aluFireY  = '0;
    bit           aluFire   = 1'b0;
    bit           forceFin  = 1'b0;
    bit           rspHold   = 1'b0;
    bit           rspRandom = 1'b0;

    always @(posedge clock) begin
        #2;
        aluFire  = 1'b0;
        aluFireY = aluHeldY;
        if (aluCd > 0) begin
            aluCd--;
            if (aluCd == 0) aluFire = 1'b1;
        end
        if (bus.alu_start === 1'b1) begin
            aluCd    = (latQ.size() > 0) ? latQ.pop_front() : 0;
            aluHeldY = aluRef(bus.alu_opcode, bus.alu_a, bus.alu_b);
        end
        bus.alu_finished = aluFire | forceFin;
        bus.alu_y        = aluFire ? aluFireY : N'($urandom);
        bus.rsp_ready    = rspHold ? 1'b0 : (rspRandom ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    // Transaction-level model state and DUT observation logs.
    bit           mActive    = 1'b0;
    bit           mResolved  = 1'b0;
    bit           mTo        = 1'b0;
    int           mAcceptCyc = 0;
    int           mRspFrom   = 0;
    int           mRspCount  = 0;
    logic [4:0]   mOp        = '0;
    logic [N-1:0] mA         = '0;
    logic [N-1:0] mB         = '0;
    logic [N-1:0] mY         = '0;
    bit           expStart;
    bit           expValid;
    bit           expReady;

    int           dutRspCount   = 0;
    int           lastAcceptCyc = 0;
    int           lastStartCyc  = 0;
    int           lastRiseCyc   = 0;
    logic [N-1:0] lastRspY      = '0;
    bit           lastRspTo     = 1'b0;
    bit           prevValid     = 1'b0;
    int           startQ[$];
    logic [N-1:0] yLog[$];

    always @(negedge clock) begin
        if (reset) begin
            checkOutput("rst_busy", bus.busy, 0);
            checkOutput("rst_cmd_ready", bus.cmd_ready, 0);
            checkOutput("rst_alu_start", bus.alu_start, 0);
            checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
            checkOutput("rst_rsp_timeout", bus.rsp_timeout, 0);
            checkOutput("rst_rsp_y", bus.rsp_y, 0);
            checkOutput("rst_alu_opcode", bus.alu_opcode, 0);
            checkOutput("rst_alu_a", bus.alu_a, 0);
            checkOutput("rst_alu_b", bus.alu_b, 0);
            mActive   = 1'b0;
            mOp       = '0;
            mA        = '0;
            mB        = '0;
            prevValid = 1'b0;
        end else begin
            expStart = mActive && (cyc == mAcceptCyc + 1);
            expValid = mActive && mResolved && (cyc >= mRspFrom);
            expReady = !mActive && !bus.alu_finished;
            checkOutput("busy", bus.busy, mActive);
            checkOutput("cmd_ready", bus.cmd_ready, expReady);
            checkOutput("alu_start", bus.alu_start, expStart);
            checkOutput("rsp_valid", bus.rsp_valid, expValid);
            checkOutput("alu_opcode", bus.alu_opcode, mOp);
            checkOutput("alu_a", bus.alu_a, mA);
            checkOutput("alu_b", bus.alu_b, mB);
            if (expValid) begin
                checkOutput("rsp_y", bus.rsp_y, mY);
                checkOutput("rsp_timeout", bus.rsp_timeout, mTo);
            end

            if (bus.cmd_valid && bus.cmd_ready) lastAcceptCyc = cyc;
            if (bus.alu_start) begin
                lastStartCyc = cyc;
                startQ.push_back(cyc);
            end
            if (bus.rsp_valid && !prevValid) lastRiseCyc = cyc;
            if (bus.rsp_valid && bus.rsp_ready) begin
                dutRspCount++;
                lastRspY  = bus.rsp_y;
                lastRspTo = bus.rsp_timeout;
                yLog.push_back(bus.rsp_y);
            end
            prevValid = bus.rsp_valid;

            // Start is the cycle after accept; the wait window is the TIMEOUT-1 cycles after start.
            if (mActive && !mResolved && (cyc >= mAcceptCyc + 2)) begin
                if (bus.alu_finished) begin
                    mResolved = 1'b1;
                    mRspFrom  = cyc + 1;
                    mY        = aluRef(mOp, mA, mB);
                    mTo       = 1'b0;
                end else if (cyc == mAcceptCyc + TIMEOUT) begin
                    mResolved = 1'b1;
                    mRspFrom  = cyc + 1;
                    mY        = '0;
                    mTo       = 1'b1;
                end
            end
            if (expValid && bus.rsp_ready) begin
                mActive = 1'b0;
                mRspCount++;
            end else if (expReady && bus.cmd_valid) begin
                mActive    = 1'b1;
                mResolved  = 1'b0;
                mAcceptCyc = cyc;
                mOp        = bus.cmd_opcode;
                mA         = bus.cmd_a;
                mB         = bus.cmd_b;
            end
        end
    end

    task automatic applyStimulus(input logic [4:0] op, input logic [N-1:0] a,
                                 input logic [N-1:0] b, input int lat, input bit keep);
        int  guard;
        bit  accepted;
        latQ.push_back(lat);
        bus.cmd_opcode = op;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        bus.cmd_valid  = 1'b1;
        guard    = 0;
        accepted = 1'b0;
        while (!accepted && guard < 200) begin
            @(negedge clock);
            if (bus.cmd_ready) accepted = 1'b1;
            @(posedge clock);
            #1;
            guard++;
        end
        checkOutput("cmd_accepted", accepted, 1);
        if (!keep) bus.cmd_valid = 1'b0;
    endtask

    task automatic waitRsp(input int target);
        int guard;
        guard = 0;
        while (dutRspCount < target && guard < 300) begin
            @(posedge clock);
            #1;
            guard++;
        end
        checkOutput("rsp_arrived", dutRspCount >= target, 1);
    endtask

    initial begin
        int base;
        int sb;
        int g;
        bus.cmd_valid    = 1'b0;
        bus.cmd_opcode   = '0;
        bus.cmd_a        = '0;
        bus.cmd_b        = '0;
        bus.alu_finished = 1'b0;
        bus.alu_y        = '0;
        bus.rsp_ready    = 1'b1;
        repeat (3) @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock);
        #1;

        $display("[TB] single operation");
        base = dutRspCount;
        applyStimulus(5'h00, 4'h3, 4'h4, 3, 1'b0);
        waitRsp(base + 1);
        checkOutput("single_start_lat", lastStartCyc - lastAcceptCyc, 1);
        checkOutput("single_rsp_lat", lastRiseCyc - lastStartCyc, 4);
        checkOutput("single_y", lastRspY, 4'h7);
        checkOutput("single_to", lastRspTo, 0);

        $display("[TB] response backpressure");
        base    = dutRspCount;
        rspHold = 1'b1;
        applyStimulus(5'h00, 4'h3, 4'h4, 3, 1'b0);
        g = 0;
        while (!bus.rsp_valid && g < 50) begin
            @(negedge clock);
            g++;
        end
        checkOutput("bp_valid_seen", bus.rsp_valid, 1);
        repeat (5) begin
            checkOutput("bp_valid_held", bus.rsp_valid, 1);
            checkOutput("bp_y_held", bus.rsp_y, 4'h7);
            checkOutput("bp_cmd_ready", bus.cmd_ready, 0);
            @(negedge clock);
        end
        @(posedge clock);
        #1 rspHold = 1'b0;
        @(negedge clock);
        checkOutput("bp_accept_valid", bus.rsp_valid, 1);
        checkOutput("bp_accept_ready", bus.rsp_ready, 1);
        @(negedge clock);
        checkOutput("bp_released", bus.rsp_valid, 0);
        checkOutput("bp_count", dutRspCount, base + 1);
        checkOutput("bp_y", lastRspY, 4'h7);
        @(posedge clock);
        #1;

        $display("[TB] timeout");
        base = dutRspCount;
        applyStimulus(5'h01, 4'h9, 4'h2, 0, 1'b0);
        waitRsp(base + 1);
        checkOutput("to_rsp_lat", lastRiseCyc - lastStartCyc, 8);
        checkOutput("to_y", lastRspY, 0);
        checkOutput("to_flag", lastRspTo, 1);
        repeat (2) @(posedge clock);
        #1 forceFin = 1'b1;
        @(posedge clock);
        #1 forceFin = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        checkOutput("stray_no_rsp", dutRspCount, base + 1);
        checkOutput("stray_idle", bus.busy, 0);

        $display("[TB] timeout and finished on the same cycle");
        base = dutRspCount;
        applyStimulus(5'h00, 4'h5, 4'h6, TIMEOUT - 1, 1'b0);
        waitRsp(base + 1);
        checkOutput("tie_rsp_lat", lastRiseCyc - lastStartCyc, 8);
        checkOutput("tie_y", lastRspY, 4'hB);
        checkOutput("tie_to", lastRspTo, 0);

        $display("[TB] back-to-back");
        base = dutRspCount;
        sb   = startQ.size();
        applyStimulus(5'h00, 4'h1, 4'h2, 3, 1'b1);
        applyStimulus(5'h00, 4'hF, 4'h1, 3, 1'b0);
        waitRsp(base + 2);
        checkOutput("b2b_starts", startQ.size() - sb, 2);
        if (startQ.size() >= sb + 2) checkOutput("b2b_spacing", startQ[sb+1] - startQ[sb], 6);
        if (yLog.size() >= base + 2) begin
            checkOutput("b2b_y0", yLog[base], 4'h3);
            checkOutput("b2b_y1", yLog[base+1], 4'h0);
        end

        $display("[TB] reset during wait");
        base = dutRspCount;
        applyStimulus(5'h02, 4'hA, 4'h5, 5, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #2;
        checkOutput("pre_rst_busy", bus.busy, 1);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_rst_busy", bus.busy, 0);
        checkOutput("async_rst_valid", bus.rsp_valid, 0);
        checkOutput("async_rst_start", bus.alu_start, 0);
        checkOutput("async_rst_ready", bus.cmd_ready, 0);
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        checkOutput("rst_no_rsp", dutRspCount, base);
        applyStimulus(5'h03, 4'hC, 4'hA, 2, 1'b0);
        waitRsp(base + 1);
        checkOutput("post_rst_y", lastRspY, 4'h8);
        checkOutput("post_rst_to", lastRspTo, 0);

        $display("[TB] randomised operations");
        rspRandom = 1'b1;
        sb = dutRspCount;
        for (int i = 0; i < 60; i++) begin
            base = dutRspCount;
            applyStimulus(5'($urandom), N'($urandom), N'($urandom), $urandom_range(0, 10), 1'b0);
            waitRsp(base + 1);
            if ($urandom_range(0, 3) == 0) begin
                forceFin = 1'b1;
                repeat (3) @(posedge clock);
                #1;
                checkOutput("level_blocks_cmd", bus.cmd_ready, 0);
                forceFin = 1'b0;
                repeat (2) @(posedge clock);
                #1;
            end
        end
        rspRandom = 1'b0;
        checkOutput("rand_rsp_count", dutRspCount, sb + 60);
        checkOutput("model_rsp_count", mRspCount, dutRspCount);

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/alu_issuer.md
Name: alu_issuer

Overview:
- Initiator for the ALU start/finished handshake. It owns the `start`, `opcode`, `A` and `B` lines and consumes `finished` and `Y`.
- It accepts operation commands from a controller over a valid/ready interface and launches each one on the ALU.
- It waits for completion, or gives up after a timeout, then returns the result over a valid/ready response channel.
- It sits between the sequencing logic and the ALU, so upstream blocks never touch ALU handshake timing.

Parameters:
- N, 4, datapath width; must match the attached ALU.
- TIMEOUT, 64, maximum cycles spent in WAIT before the operation is abandoned; legal range 2..65535.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  a command is offered.
- cmd_ready  output  1  the issuer can accept a command this cycle.
- cmd_opcode  input  5  operation code to launch.
- cmd_a  input  N  operand A.
- cmd_b  input  N  operand B.
- alu_start  output  1  start pulse to the ALU.
- alu_finished  input  1  completion flag from the ALU.
- alu_opcode  output  5  registered opcode to the ALU.
- alu_a  output  N  registered operand A.
- alu_b  output  N  registered operand B.
- alu_y  input  N  ALU result.
- rsp_valid  output  1  a response is held.
- rsp_ready  input  1  the consumer takes the response.
- rsp_y  output  N  captured result; 0 on timeout.
- rsp_timeout  output  1  1 = operation abandoned after TIMEOUT cycles.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous, active-high. While reset is high, or on the first edge after it falls:
  - state = IDLE;
  - alu_start = 0; alu_opcode/alu_a/alu_b = 0;
  - rsp_valid = 0; rsp_y = 0; rsp_timeout = 0;
  - busy = 0; cmd_ready = 0; timeout counter = 0.
- Reset mid-operation abandons the operation. No response is produced and any later stray `alu_finished` is ignored.
- States are IDLE, LAUNCH, WAIT, RESPOND.
- IDLE:
  - cmd_ready = 1 only when `alu_finished` = 0; it is combinational from state and `alu_finished`.
  - On cmd_valid & cmd_ready, register opcode/A/B onto alu_* and go to LAUNCH.
  - `alu_finished` seen in IDLE is ignored.
- LAUNCH:
  - alu_start = 1 for exactly this one cycle; clear the counter; next state is WAIT.
- WAIT:
  - alu_start = 0; alu_opcode/a/b stay stable.
  - The counter increments every cycle.
  - If `alu_finished` = 1: capture alu_y into rsp_y, set rsp_timeout = 0, and go to RESPOND.
  - Otherwise, if the counter reaches TIMEOUT-1: set rsp_y = 0, rsp_timeout = 1, and go to RESPOND.
  - If finished arrives on the same cycle the timeout expires, finished wins and the result is captured.
- RESPOND:
  - rsp_valid = 1. rsp_y and rsp_timeout are held stable until rsp_ready = 1.
  - On rsp_valid & rsp_ready, go to IDLE with rsp_valid = 0 on the next cycle.
  - cmd_ready = 0 in this state, so there is never more than one operation outstanding.
- Latency:
  - Command accepted at edge k gives alu_start high during cycle k+1.
  - finished first high in cycle m gives rsp_valid high from cycle m+1.
  - Minimum command-to-response time is 3 cycles. Back-to-back throughput is one operation per (ALU latency + 3) cycles.
- The counter is sized as clog2(TIMEOUT) bits and never wraps, because it is cleared in LAUNCH.
- An `alu_finished` that stays high as a level is tolerated: a new command is blocked until it drops.

Test Plan:
- Single op, ALU model Y = A + B after 3 cycles. cmd opcode=5'h00, A=4'h3, B=4'h4 → one alu_start pulse exactly 1 cycle after accept; rsp_valid 4 cycles after alu_start; rsp_y = 4'h7; rsp_timeout = 0.
- Response backpressure. Same op with rsp_ready held low for 5 cycles → rsp_valid and rsp_y = 4'h7 stay stable; cmd_ready = 0 throughout; the response is accepted on the cycle rsp_ready rises.
- Timeout. ALU model never asserts finished, TIMEOUT = 8 → rsp_valid exactly 8 cycles after alu_start with rsp_y = 0 and rsp_timeout = 1. A later finished pulse in IDLE produces no response.
- Timeout/finished tie. finished asserted on the cycle the counter hits TIMEOUT-1 → rsp_timeout = 0 and rsp_y equals the ALU result.
- Back-to-back. Two commands (A=1,B=2 then A=4'hF,B=4'h1), cmd_valid held high, rsp_ready = 1 → two alu_start pulses with no overlap; responses 4'h3 then 4'h0 (wrap-around), in order.
- Reset mid-WAIT. Assert reset 2 cycles after alu_start → busy, rsp_valid and alu_start go to 0 immediately without waiting for a clock edge; no response after release; the next command completes normally.
